mc_ctrl_ws: RTL
===============

Name: mc_ctrl_ws

Overview:
Parametrised multi-cycle control unit for the CHARM-style datapath (IFSTAGE/DECSTAGE/ALUSTAGE/MEMSTAGE). Drives the same datapath control signals as the single-cycle controller. Adds:
- configurable instruction-fetch wait states,
- a req/ack handshake to a variable-latency data memory, with timeout,
- a sticky halt on illegal opcode or timeout,
- a retired-instruction counter.

Parameters:
FETCH_CYCLES, 1, cycles spent in FETCH before IR load (>=1)
TIMEOUT, 16, max cycles in MEM without mem_ack before error halt (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
instr  in  32  current instruction (opcode [31:26], func [3:0])
zero_out  in  1  ALU zero flag
mem_ack  in  1  data memory done; one-cycle pulse
pc_sel  out  1  0: PC+4, 1: PC+4+immed
pc_lden  out  1  PC load enable
ir_lden  out  1  instruction register load
rf_b_sel  out  1  1: read rd as RF port B (I-type, store, branch)
rf_wrdata_sel  out  1  0: alu_out, 1: mem_dataout
rf_wren  out  1  register file write
alu_bin_sel  out  1  0: rf_b, 1: immed
alu_func  out  4  ALU operation
mem_req  out  1  data memory request
mem_wren  out  1  data memory write
mem_byteop  out  1  byte access
halted  out  1  sticky halt
err  out  1  sticky: halt caused by memory timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset low, asynchronous: state=FETCH; wait counter, timeout counter and instret cleared; halted=err=0. All outputs are Moore/registered-state decoded and are 0 in reset.
- Opcodes:
  - 100000 R-type: alu_func=instr[3:0]
  - 111000 li, 111001 lui, 110000 addi: ADD 0000
  - 110010 andi: 0010
  - 110011 ori: 0011
  - 111111 b
  - 000000 beq, 000001 bne: SUB 0001
  - 000011 lb, 001111 lw, 000111 sb, 011111 sw: ADD
  - Any other opcode is illegal.
- FETCH: stay FETCH_CYCLES cycles. ir_lden=1 in the last cycle only, then -> DECODE.
- DECODE, 1 cycle:
  - illegal -> HALT
  - b -> BRANCH
  - otherwise -> EXEC
- EXEC, 1 cycle:
  - alu_func, alu_bin_sel and rf_b_sel are valid from EXEC through the end of the instruction.
  - R-type -> WB.
  - Immediate ALU ops -> WB with alu_bin_sel=1.
  - Loads/stores -> MEM with alu_bin_sel=1.
  - beq/bne: pc_lden=1, pc_sel=zero_out (beq) or ~zero_out (bne), retire, -> FETCH.
- MEM:
  - mem_req=1; mem_wren=1 for sb/sw; mem_byteop=1 for lb/sb. These are held stable until ack.
  - On mem_ack, load -> WB with rf_wrdata_sel=1.
  - On mem_ack, store: pc_lden=1, pc_sel=0, retire, -> FETCH.
  - If the timeout counter reaches TIMEOUT without ack -> HALT with err=1.
  - An ack arriving in the same cycle the counter expires wins (no error).
  - mem_ack outside MEM is ignored.
- WB: rf_wren=1, pc_lden=1, pc_sel=0, retire, -> FETCH. rf_wrdata_sel holds its MEM value for loads.
- BRANCH: pc_lden=1, pc_sel=1, retire, -> FETCH.
- HALT: halted=1 and all enables 0. Exit only via Reset.
- Retire: instret+1 in the retiring cycle; saturates at all-ones.
- Latency with FETCH_CYCLES=F and ack after n MEM cycles:
  - ALU op: F+3 cycles
  - beq/bne and b: F+2 cycles
  - store: F+2+n cycles
  - load: F+3+n cycles
- Reset asserted mid-instruction aborts it with no retire; it restarts in FETCH after release.

Test Plan:
- F=1, add r1,r2,r3 (opcode 100000, func 0000) -> 4-cycle sequence; rf_wren=1 only in cycle 4 with alu_func=0000, alu_bin_sel=0; instret 0->1.
- F=3, addi -> ir_lden pulses only in the third FETCH cycle; total 6 cycles; alu_bin_sel=1 in EXEC and WB.
- lw with mem_ack after 5 MEM cycles -> mem_req high exactly 5 cycles; WB has rf_wrdata_sel=1, rf_wren=1; total 9 cycles at F=1.
- beq with zero_out=1 -> pc_sel=1, pc_lden=1 in EXEC. bne with zero_out=1 -> pc_sel=0. Each retires in 3 cycles at F=1.
- sw with mem_ack never asserted, TIMEOUT=16 -> after 16 MEM cycles halted=1, err=1; subsequent instructions and late acks are ignored; Reset low clears both.
- Illegal opcode 010101 -> HALT after DECODE, err=0, instret unchanged. Separately, Reset pulsed during MEM -> all outputs 0 immediately and FETCH resumes after release.

Source files
------------

// File: rtl/mc_ctrl_ws_if.sv
// mc_ctrl_ws_if: control bundle between the multi-cycle controller and the datapath
interface mc_ctrl_ws_if #(parameter int CNT_W = 32);
    logic [31:0]      instr;
    logic             zero_out;
    logic             mem_ack;
    logic             pc_sel;
    logic             pc_lden;
    logic             ir_lden;
    logic             rf_b_sel;
    logic             rf_wrdata_sel;
    logic             rf_wren;
    logic             alu_bin_sel;
    logic [3:0]       alu_func;
    logic             mem_req;
    logic             mem_wren;
    logic             mem_byteop;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instret;
    modport master (
        input  instr, zero_out, mem_ack,
        output pc_sel, pc_lden, ir_lden, rf_b_sel, rf_wrdata_sel, rf_wren, alu_bin_sel,
               alu_func, mem_req, mem_wren, mem_byteop, halted, err, instret
    );
    modport slave (
        output instr, zero_out, mem_ack,
        input  pc_sel, pc_lden, ir_lden, rf_b_sel, rf_wrdata_sel, rf_wren, alu_bin_sel,
               alu_func, mem_req, mem_wren, mem_byteop, halted, err, instret
    );
endinterface

// File: rtl/mc_ctrl_ws.sv
// mc_ctrl_ws: multi-cycle CHARM control unit with fetch wait states, mem handshake/timeout, sticky halt
module mc_ctrl_ws #(
    parameter int FETCH_CYCLES = 1,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    mc_ctrl_ws_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT} state_t;
    localparam int WW = FETCH_CYCLES > 1 ? $clog2(FETCH_CYCLES) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t           state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire, last, act;
    logic [5:0]       op;
    logic             is_r, is_imm, is_b, is_beq, is_bne, is_load, is_store, is_byte, legal;
    logic [3:0]       alu_fn;
    assign op       = bus.instr[31:26];
    assign is_r     = op == 6'b100000;
    assign is_imm   = op inside {6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011};
    assign is_b     = op == 6'b111111;
    assign is_beq   = op == 6'b000000;
    assign is_bne   = op == 6'b000001;
    assign is_load  = op inside {6'b000011, 6'b001111};
    assign is_store = op inside {6'b000111, 6'b011111};
    assign is_byte  = op inside {6'b000011, 6'b000111};
    assign legal    = is_r | is_imm | is_b | is_beq | is_bne | is_load | is_store;
    assign alu_fn   = is_r ? bus.instr[3:0] : op == 6'b110010 ? 4'b0010 :
                      op == 6'b110011 ? 4'b0011 : (is_beq | is_bne) ? 4'b0001 : 4'b0000;
    assign last     = wcnt_q == WW'(FETCH_CYCLES - 1);
    assign act      = state_q inside {EXEC, MEM, WB};
    assign bus.alu_func      = act ? alu_fn : 4'b0000;
    assign bus.alu_bin_sel   = act & (is_imm | is_load | is_store);
    assign bus.rf_b_sel      = act & (is_imm | is_store | is_beq | is_bne);
    assign bus.rf_wrdata_sel = is_load & (state_q inside {MEM, WB});
    assign bus.halted        = state_q == HALT;
    assign bus.err           = err_q;
    assign bus.instret       = instret_q;
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= FETCH;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end
    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        retire         = 1'b0;
        bus.ir_lden    = 1'b0;
        bus.pc_lden    = 1'b0;
        bus.pc_sel     = 1'b0;
        bus.rf_wren    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_wren   = 1'b0;
        bus.mem_byteop = 1'b0;
        case (state_q)
            FETCH: begin
                // FETCH is the reset state, so the IR strobe must be masked while Reset is held
                bus.ir_lden = last & Reset;
                state_d     = last ? DECODE : FETCH;
            end
            DECODE: state_d = !legal ? HALT : is_b ? BRANCH : EXEC;
            EXEC: begin
                if (is_beq | is_bne) begin
                    bus.pc_lden = 1'b1;
                    bus.pc_sel  = is_beq ? bus.zero_out : ~bus.zero_out;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end else begin
                    state_d = (is_load | is_store) ? MEM : WB;
                end
            end
            MEM: begin
                bus.mem_req    = 1'b1;
                bus.mem_wren   = is_store;
                bus.mem_byteop = is_byte;
                if (bus.mem_ack) begin
                    bus.pc_lden = is_store;
                    retire      = is_store;
                    state_d     = is_store ? FETCH : WB;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end
            end
            WB: begin
                bus.rf_wren = 1'b1;
                bus.pc_lden = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                bus.pc_lden = 1'b1;
                bus.pc_sel  = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = HALT;
        endcase
        wcnt_d    = (state_q == FETCH && !last) ? wcnt_q + 1'b1 : '0;
        tcnt_d    = (state_q == MEM && state_d == MEM) ? tcnt_q + 1'b1 : '0;
        instret_d = (retire && !(&instret_q)) ? instret_q + 1'b1 : instret_q;
    end
endmodule
